// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam logic [3:0] SAMPLE_LO  = 4'd6;
  localparam logic [3:0] SAMPLE_MID = 4'd7;
  localparam logic [3:0] SAMPLE_HI  = 4'd8;
  localparam logic [3:0] PHASE_LAST = 4'd15;
  localparam int         DATA_BITS  = 8;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV sysclk cycles.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic sysclk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 receiver with 16x oversampling, majority-vote sampling and a show-ahead FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE_DIV = 651,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 tick;

  rx_state_e            state, state_n;
  logic [3:0]           phase, phase_n;
  logic [2:0]           bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [1:0]           samp, samp_n;
  logic                 vote;
  logic                 push, ferr_n;

  logic [AW:0]          wr_ptr, rd_ptr;
  logic [7:0]           mem [FIFO_DEPTH];
  logic                 empty, full, do_pop, do_push, ovr_n;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  uart_baud_tick #(.DIV(OVERSAMPLE_DIV)) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .tick   (tick)
  );

  // Vote uses the two held samples plus the live phase-8 sample.
  assign vote = maj3({rx_s, samp});

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      phase  <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      samp   <= '0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      samp   <= samp_n;
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    samp_n   = samp;
    push     = 1'b0;
    ferr_n   = 1'b0;
    if (tick) begin
      phase_n = phase + 4'd1;
      if (phase == SAMPLE_LO)  samp_n[0] = rx_s;
      if (phase == SAMPLE_MID) samp_n[1] = rx_s;
      case (state)
        IDLE: begin
          phase_n = '0;
          if (!rx_s) state_n = START;
        end
        START: begin
          if (phase == SAMPLE_HI && vote) state_n = IDLE;
          else if (phase == PHASE_LAST) begin
            bitcnt_n = '0;
            state_n  = DATA;
          end
        end
        DATA: begin
          if (phase == SAMPLE_HI) shreg_n = {vote, shreg[DATA_BITS-1:1]};
          if (phase == PHASE_LAST) begin
            if (bitcnt == 3'(DATA_BITS - 1)) state_n = STOP;
            else                             bitcnt_n = bitcnt + 3'd1;
          end
        end
        STOP: begin
          // Leave at phase 8 so a back-to-back start edge is not missed.
          if (phase == SAMPLE_HI) begin
            if (vote) begin
              push    = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: if (rx_s) state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rd_en & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovr_n   = push & full & ~do_pop;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  assign rx_data  = mem[rd_ptr[AW-1:0]];
  assign rx_valid = ~empty;
  assign rx_full  = full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo with a 4-cycle tick divider (64 cycles per bit).
module tb_uart_rx_fifo;

  localparam int DIV = 4;
  localparam int BIT = DIV * 16;
  localparam int TO  = 40 * BIT;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_valid, rx_full, frame_err, overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  logic [7:0] sb[$];

  uart_rx_fifo #(.OVERSAMPLE_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .rx        (rx),
    .rd_en     (rd_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_full   (rx_full),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge sysclk);
    end
    rx = stop;
    repeat (BIT) @(negedge sysclk);
  endtask

  task automatic pop_check(input string tag);
    int k = 0;
    logic [7:0] exp;
    while (!rx_valid && k < TO) begin
      @(negedge sysclk);
      k++;
    end
    if (!rx_valid) chk({tag, "_timeout"}, 32'(rx_valid), 32'd1);
    else begin
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk(tag, 32'(rx_data), 32'(exp));
      rd_en = 1'b1;
      @(negedge sysclk);
      rd_en = 1'b0;
    end
  endtask

  // Raises rd_en in the exact cycle the receiver issues its push strobe.
  task automatic pop_at_push(input string tag, input logic fifo_has_data);
    int k = 0;
    do begin
      @(negedge sysclk);
      k++;
    end while (!dut.push && k < TO);
    if (!dut.push) chk({tag, "_timeout"}, 32'(dut.push), 32'd1);
    else begin
      if (fifo_has_data) chk(tag, 32'(rx_data), 32'(sb.pop_front()));
      rd_en = 1'b1;
      @(negedge sysclk);
      rd_en = 1'b0;
    end
  endtask

  initial begin
    int f0, o0;
    reset = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_data",  32'(rx_data),   32'h00);
    chk("rst_valid", 32'(rx_valid),  32'd0);
    chk("rst_full",  32'(rx_full),   32'd0);
    chk("rst_ferr",  32'(frame_err), 32'd0);
    chk("rst_ovr",   32'(overrun),   32'd0);
    reset = 1'b0;
    idle(2 * BIT);

    // Two frames back to back
    f0 = n_ferr; o0 = n_ovr;
    sb.push_back(8'h24); send_byte(8'h24, 1'b1);
    sb.push_back(8'h30); send_byte(8'h30, 1'b1);
    idle(BIT);
    pop_check("b2b_0");
    pop_check("b2b_1");
    chk("b2b_ferr", 32'(n_ferr - f0), 32'd0);
    chk("b2b_ovr",  32'(n_ovr - o0),  32'd0);

    // Two-tick glitch on idle line
    f0 = n_ferr;
    rx = 1'b0;
    repeat (2 * DIV) @(negedge sysclk);
    idle(3 * BIT);
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_ferr",  32'(n_ferr - f0), 32'd0);

    // Framing error followed by a long break
    f0 = n_ferr; o0 = n_ovr;
    send_byte(8'h55, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT) @(negedge sysclk);
    idle(2 * BIT);
    chk("ferr_count", 32'(n_ferr - f0), 32'd1);
    chk("ferr_valid", 32'(rx_valid), 32'd0);
    sb.push_back(8'hA5); send_byte(8'hA5, 1'b1);
    idle(BIT);
    pop_check("ferr_next");
    chk("ferr_ovr", 32'(n_ovr - o0), 32'd0);

    // Overrun on fifth frame without popping
    o0 = n_ovr;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    chk("ovr_full", 32'(rx_full), 32'd1);
    send_byte(8'h05, 1'b1);
    idle(BIT);
    chk("ovr_pulse", 32'(n_ovr - o0), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("ovr_pop");
    chk("ovr_empty", 32'(rx_valid), 32'd0);

    // Push and pop in the same cycle while full
    o0 = n_ovr;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    chk("sim_full", 32'(rx_full), 32'd1);
    sb.push_back(8'h05);
    fork
      send_byte(8'h05, 1'b1);
      pop_at_push("sim_full_pop", 1'b1);
    join
    idle(BIT);
    chk("sim_full_ovr", 32'(n_ovr - o0), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("sim_full_drain");
    chk("sim_full_empty", 32'(rx_valid), 32'd0);

    // Pop strobe on an empty FIFO in the push cycle
    sb.push_back(8'h6E);
    fork
      send_byte(8'h6E, 1'b1);
      pop_at_push("sim_empty", 1'b0);
    join
    idle(BIT);
    chk("sim_empty_valid", 32'(rx_valid), 32'd1);
    pop_check("sim_empty_data");

    // Reset in the middle of a frame
    sb.push_back(8'h99); send_byte(8'h99, 1'b1);
    idle(BIT);
    chk("pre_rst_valid", 32'(rx_valid), 32'd1);
    rx = 1'b0;
    repeat (BIT) @(negedge sysclk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h3C >> i);
      repeat (BIT) @(negedge sysclk);
    end
    rx = 1'b1;
    repeat (BIT / 2) @(negedge sysclk);
    reset = 1'b1;
    #1;
    chk("mid_rst_data",  32'(rx_data),   32'h00);
    chk("mid_rst_valid", 32'(rx_valid),  32'd0);
    chk("mid_rst_full",  32'(rx_full),   32'd0);
    chk("mid_rst_ferr",  32'(frame_err), 32'd0);
    chk("mid_rst_ovr",   32'(overrun),   32'd0);
    sb.delete();
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    f0 = n_ferr; o0 = n_ovr;
    idle(2 * BIT);
    sb.push_back(8'h3C); send_byte(8'h3C, 1'b1);
    idle(BIT);
    pop_check("post_rst");
    chk("post_rst_flags", 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);
    chk("post_rst_empty", 32'(rx_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end feeding the pipelined CPU's UART peripheral. Synchronises the asynchronous `rx` line and samples it at 16x the baud rate, validates start bits and recovers 8N1 frames LSB-first. Received bytes are buffered in a small show-ahead FIFO, which the CPU pops with a single-cycle read strobe. Framing and overrun conditions are flagged to the CPU as pulses.

## Interface
- `OVERSAMPLE_DIV`, 651: sysclk cycles per 16x sample tick (100 MHz / 9600 baud / 16).
- `FIFO_DEPTH`, 4: receive buffer entries; power of two, ≥2.
- `sysclk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high.
- `rx` in 1: serial line, idle high, asynchronous to `sysclk`.
- `rd_en` in 1: pops the FIFO head this cycle; ignored when empty.
- `rx_data` out 8: FIFO head byte; valid while `rx_valid`=1.
- `rx_valid` out 1: FIFO non-empty.
- `rx_full` out 1: FIFO full.
- `frame_err` out 1: one-cycle pulse when a stop bit samples 0.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, both reset to 1, giving `rx_s`. Only `rx_s` is used downstream.
- **Tick generator:** counts 0..`OVERSAMPLE_DIV`-1 and pulses `tick` for one cycle at terminal count. It free-runs from reset.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. `phase` is 4 bits and counts ticks 0..15 within a bit. `bitcnt` is 3 bits.
- **IDLE:** on a tick with `rx_s`=0, set `phase`=0 and go to START.
- **START:** capture samples at phase 6, 7 and 8. At phase 8, take the majority vote.
  - Vote 1: false start, return to IDLE.
  - Vote 0: continue to the end of the bit.
  - At phase 15: `phase`←0, `bitcnt`←0, go to DATA.
- **DATA:** sample at phase 6/7/8; the majority vote is shifted into `shreg[7]` at phase 8, with a right shift so the byte arrives LSB-first. At phase 15: if `bitcnt`=7 go to STOP, else `bitcnt`++.
- **STOP:** majority vote at phase 8, then go to IDLE immediately. This allows a back-to-back start edge to be detected from phase 9 onward.
  - Vote 1: push `shreg`. If the FIFO is full and no pop occurs this cycle, drop the byte and pulse `overrun`.
  - Vote 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until a tick with `rx_s`=1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- **FIFO:** pointers of log2(`FIFO_DEPTH`)+1 bits, wrapping modulo 2·`FIFO_DEPTH`.
  - Empty: pointers are equal.
  - Full: MSBs differ and the remaining bits are equal.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This holds when full, with no overrun, and when empty, where the push wins.
  - A pop when empty has no effect.
- **Reset:** clears state to IDLE, the tick counter, `phase`, `bitcnt`, `shreg` (0x00), FIFO pointers and both pulse flops, and sets the synchroniser to 1. A frame in progress at reset is lost with no flags raised.

## Timing
- **Output reset values:**
  - `rx_data`=0x00.
  - `rx_valid`=0, `rx_full`=0.
  - `frame_err`=0, `overrun`=0.
- **Line to `rx_s`:** 2 sysclk cycles.
- **Push to `rx_valid`:** `rx_valid` rises the cycle after the push-edge (registered pointers), and `rx_data` is stable from that cycle.
- **Pop:** `rd_en` with `rx_valid`=1 advances the head. The new `rx_data`/`rx_valid` appear the next cycle.
- **Pulses:** `frame_err`/`overrun` are registered and high for exactly one cycle, the cycle after the STOP phase-8 tick.
- **Frame duration:** start edge to push is 9.5 bit times ±1 tick, plus 2 sync cycles.
- **Baud tolerance:** sampling at mid-bit tolerates ±3% baud mismatch.

## Structure
- **Package `uart_pkg`:**
  - state encoding enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - `SAMPLE_LO`=6, `SAMPLE_MID`=7, `SAMPLE_HI`=8, `PHASE_LAST`=15;
  - `DATA_BITS`=8.
- **Sub-module `uart_baud_tick`:** the parameterised divider (`sysclk`, `reset` → `tick`). It is reused by the future transmitter.
- The FIFO stays inline; it is too small to warrant a module.
- Estimated size: ~250 RTL lines.

## Test plan
All scenarios run with `OVERSAMPLE_DIV`=4, so one bit is 64 cycles.
- **Two frames:** send 0x24, then 0x30 with no idle gap. Required: two pushes, `rx_data`=0x24 then 0x30 after two `rd_en` pops, and no flags.
- **Glitch rejection:** a low glitch of 2 ticks on an idle line. Required: return to IDLE, no push, `rx_valid` stays 0.
- **Framing error:** frame 0x55 with stop bit 0, held low for 3 bit times. Required: exactly one `frame_err` pulse, no push, and the following 0xA5 frame is received correctly.
- **Overrun:** five frames (0x01..0x05) without popping. Required: `rx_full`=1 after 0x04, and the 0x05 push produces an `overrun` pulse. Popping all entries yields 0x01..0x04, after which `rx_valid`=0.
- **Simultaneous push/pop:**
  - With the FIFO full, assert `rd_en` in the push cycle of 0x05: no overrun, and entries read out 0x02..0x05.
  - With the FIFO empty, `rd_en` in the push cycle is ignored and the byte is retained.
- **Reset mid-frame:** assert `reset` during DATA bit 4 of 0x3C. Required: all outputs 0 immediately (asynchronous). After release, the next frame 0x3C is received cleanly.
